// File: rtl/ps2_input_event_arbiter.sv
// ps2_input_event_arbiter
// Turns PS/2 keyboard/mouse level lines into one-shot press events. Keyboard and mouse
// requests are arbitrated round-robin. Granted events are queued in a small FIFO, which
// the game logic reads over a valid/ready handshake.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   enable      1 = capture new presses, 0 = ignore new rises (queue keeps draining)
//   user[5:0]   levels: [0]w [1]a [2]s [3]d [4]right_click [5]left_click
//   feedback    levels: [0]space [1]enter
//   flush       synchronous clear of queue, pendings and overflow
//   evt_valid   queue non-empty
//   evt_code    head event code (0 w,1 a,2 s,3 d,4 right,5 left,6 space,7 enter), 0 if empty
//   evt_ready   consumer takes the head this cycle
//   fifo_count  queue occupancy 0..FIFO_DEPTH
//   overflow    sticky, a press was lost
//   last_grant  group granted last: 0 keyboard, 1 mouse
module ps2_input_event_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [5:0]       user,
  input  logic [1:0]       feedback,
  input  logic             flush,
  output logic             evt_valid,
  output logic [2:0]       evt_code,
  input  logic             evt_ready,
  output logic [PTR_W:0]   fifo_count,
  output logic             overflow,
  output logic             last_grant
);

  localparam logic [PTR_W:0] LP_FULL    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]     LP_KB_MASK = 8'hCF;  // codes 0,1,2,3,6,7
  localparam logic [7:0]     LP_MS_MASK = 8'h30;  // codes 4,5

  logic [7:0]       r_prev;
  logic [7:0]       r_pending;
  logic [2:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic             r_last_grant;

  logic [7:0] w_lines;
  logic [7:0] w_rise;
  logic [7:0] w_set;
  logic [7:0] w_grant_onehot;
  logic [7:0] w_pending_d;
  logic       w_kb_req;
  logic       w_ms_req;
  logic [2:0] w_kb_code;
  logic [2:0] w_ms_code;
  logic       w_sel_ms;
  logic [2:0] w_grant_code;
  logic       w_full;
  logic       w_pop;
  logic       w_grant;
  logic       w_drop;

  // Line vector indexed by event code.
  assign w_lines = {feedback[1], feedback[0], user[5], user[4], user[3:0]};
  assign w_rise  = w_lines & ~r_prev;
  assign w_set   = enable ? w_rise : 8'd0;

  assign w_kb_req = |(r_pending & LP_KB_MASK);
  assign w_ms_req = |(r_pending & LP_MS_MASK);

  // Lowest pending keyboard code wins.
  always_comb begin
    w_kb_code = 3'd7;
    if (r_pending[0])      w_kb_code = 3'd0;
    else if (r_pending[1]) w_kb_code = 3'd1;
    else if (r_pending[2]) w_kb_code = 3'd2;
    else if (r_pending[3]) w_kb_code = 3'd3;
    else if (r_pending[6]) w_kb_code = 3'd6;
  end

  assign w_ms_code = r_pending[4] ? 3'd4 : 3'd5;

  // Mouse wins when it is the only requester, or when both request and keyboard went last.
  assign w_sel_ms     = w_ms_req & (~w_kb_req | ~r_last_grant);
  assign w_grant_code = w_sel_ms ? w_ms_code : w_kb_code;

  assign w_full  = (r_count == LP_FULL);
  assign w_pop   = evt_valid & evt_ready & ~flush;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign w_grant = (w_kb_req | w_ms_req) & (~w_full | w_pop) & ~flush;

  assign w_grant_onehot = w_grant ? (8'd1 << w_grant_code) : 8'd0;
  assign w_pending_d    = (r_pending & ~w_grant_onehot) | w_set;
  // A rise on a bit that stays pending is a lost press.
  assign w_drop         = |(w_set & r_pending & ~w_grant_onehot);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev       <= 8'd0;
      r_pending    <= 8'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_last_grant <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 3'd0;
      end
    end else begin
      // prev always follows the lines so held keys never retrigger after a flush.
      r_prev <= w_lines;
      if (flush) begin
        r_pending  <= 8'd0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        r_pending <= w_pending_d;
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_grant) begin
          r_mem[r_wr_ptr] <= w_grant_code;
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
          r_last_grant    <= w_sel_ms;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_grant, w_pop})
          2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
          2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign evt_valid  = (r_count != '0);
  assign evt_code   = evt_valid ? r_mem[r_rd_ptr] : 3'd0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign last_grant = r_last_grant;

endmodule
